// File: rtl/pattern_loader.sv
// Writes one preset 8x8 life pattern into the array as quadrant words and holds off steps while loading.
// Optional PATTERN_RANDOM_EN: pattern 3 writes free-running LFSR words instead of the block pattern.
module pattern_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int WORDS       = 4,
  parameter int HOLD        = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [1:0]  pattern_sel,
  input  logic        step_in,
  output logic        step_out,
  output logic [15:0] val,
  output logic [1:0]  pos,
  output logic        write_enb,
  output logic        busy,
  output logic        done
);

  localparam int         HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [1:0] LAST_IDX  = 2'(WORDS - 1);
  localparam logic [HCW-1:0] LAST_HOLD = HCW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   load_q;
  logic                   load_req;
  logic [1:0]             sel_q;
  logic [1:0]             idx;
  logic [HCW-1:0]         hold_cnt;
  logic [1:0]             word_sel;
  logic [1:0]             word_idx;
  logic [15:0]            next_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      load_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], load};
      load_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign load_req = sync_q[SYNC_STAGES-1] & ~load_q;
  assign step_out = step_in & ~busy;

  function automatic logic [15:0] table_word(input logic [1:0] s, input logic [1:0] i);
    logic [15:0] w;
    w = '0;
    case (s)
      2'd1:    w = (i == 2'd0) ? 16'h0742 : 16'h0000;
      2'd2:    w = (i == 2'd3) ? 16'h0070 : 16'h0000;
      2'd3:    w = 16'h0660;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

`ifdef PATTERN_RANDOM_EN
  logic [15:0] lfsr;
  logic [15:0] rnd_word;

  // Fibonacci taps 16,14,13,11; free-running regardless of FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign rnd_word = (lfsr == 16'h0000) ? 16'h0001 : lfsr;
`endif

  // Word selection looks one word ahead so val/pos register together with write_enb.
  always_comb begin
    word_sel = sel_q;
    word_idx = idx + 2'd1;
    if (state == IDLE) begin
      word_sel = pattern_sel;
      word_idx = 2'd0;
    end
    next_word = table_word(word_sel, word_idx);
`ifdef PATTERN_RANDOM_EN
    if (word_sel == 2'd3) next_word = rnd_word;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= '0;
      idx       <= '0;
      hold_cnt  <= '0;
      val       <= '0;
      pos       <= '0;
      write_enb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_req) begin
            state     <= WRITE;
            sel_q     <= pattern_sel;
            idx       <= '0;
            hold_cnt  <= '0;
            pos       <= '0;
            val       <= next_word;
            write_enb <= 1'b1;
            busy      <= 1'b1;
          end
        end
        WRITE: begin
          if (hold_cnt == LAST_HOLD) begin
            hold_cnt <= '0;
            if (idx == LAST_IDX) begin
              state     <= DONE;
              write_enb <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
              pos <= idx + 2'd1;
              val <= next_word;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_loader.sv
// Bench for pattern_loader: HOLD=1 and HOLD=2 instances share stimulus; expected words are queued
// per load and compared against writes captured by a negedge monitor.
module tb_pattern_loader;

  logic        clk = 1'b0;
  logic        reset, load, step_in;
  logic [1:0]  pattern_sel;
  logic        step_out, write_enb, busy, done;
  logic [15:0] val;
  logic [1:0]  pos;
  logic        step_out2, write_enb2, busy2, done2;
  logic [15:0] val2;
  logic [1:0]  pos2;

  always #5 clk = ~clk;

  pattern_loader dut (
    .clk(clk), .reset(reset), .load(load), .pattern_sel(pattern_sel), .step_in(step_in),
    .step_out(step_out), .val(val), .pos(pos), .write_enb(write_enb), .busy(busy), .done(done)
  );

  pattern_loader #(.HOLD(2)) dut_h2 (
    .clk(clk), .reset(reset), .load(load), .pattern_sel(pattern_sel), .step_in(step_in),
    .step_out(step_out2), .val(val2), .pos(pos2), .write_enb(write_enb2), .busy(busy2), .done(done2)
  );

  typedef struct packed {
    logic [1:0]       sel;
    logic [3:0][15:0] w;
  } vec_t;

  typedef struct packed {
    logic        rnd;
    logic [1:0]  pos;
    logic [15:0] val;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp1[$];
  exp_t exp2[$];

  // Reference LFSR; m_prev is the state just before the most recent edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  logic [1:0]  obs1_pos[0:1023];
  logic [15:0] obs1_val[0:1023];
  logic [15:0] obs1_ref[0:1023];
  logic [1:0]  obs2_pos[0:1023];
  logic [15:0] obs2_val[0:1023];
  logic [15:0] obs2_ref[0:1023];
  int obs1_n = 0, obs2_n = 0;
  int done1_cnt = 0, done2_cnt = 0, busy1_cnt = 0, busy2_cnt = 0;
  logic        we2_d = 1'b0;
  logic [1:0]  pos2_d = '0;
  logic [15:0] ref2 = '0;

  always @(negedge clk) begin
    if (write_enb && obs1_n < 1024) begin
      obs1_pos[obs1_n] = pos;
      obs1_val[obs1_n] = val;
      obs1_ref[obs1_n] = (m_prev == 16'h0000) ? 16'h0001 : m_prev;
      obs1_n++;
    end
    if (write_enb2 && obs2_n < 1024) begin
      if (!we2_d || pos2 != pos2_d) ref2 = (m_prev == 16'h0000) ? 16'h0001 : m_prev;
      obs2_pos[obs2_n] = pos2;
      obs2_val[obs2_n] = val2;
      obs2_ref[obs2_n] = ref2;
      obs2_n++;
    end
    we2_d  = write_enb2;
    pos2_d = pos2;
    if (done)  done1_cnt++;
    if (done2) done2_cnt++;
    if (busy)  busy1_cnt++;
    if (busy2) busy2_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [1:0] s, input logic [3:0][15:0] w);
    exp_t e;
    for (int unsigned i = 0; i < 4; i++) begin
      e.pos = 2'(i);
      e.val = w[i];
      e.rnd = 1'b0;
`ifdef PATTERN_RANDOM_EN
      if (s == 2'd3) e.rnd = 1'b1;
`endif
      exp1.push_back(e);
      exp2.push_back(e);
      exp2.push_back(e);
    end
  endtask

  int rd1 = 0, rd2 = 0;

  task automatic drain();
    exp_t e;
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      if (rd1 < obs1_n) begin
        check("h1_pos", 32'(obs1_pos[rd1]), 32'(e.pos));
        check("h1_val", 32'(obs1_val[rd1]), e.rnd ? 32'(obs1_ref[rd1]) : 32'(e.val));
        rd1++;
      end else check("h1_word_present", 0, 1);
    end
    while (exp2.size() > 0) begin
      e = exp2.pop_front();
      if (rd2 < obs2_n) begin
        check("h2_pos", 32'(obs2_pos[rd2]), 32'(e.pos));
        check("h2_val", 32'(obs2_val[rd2]), e.rnd ? 32'(obs2_ref[rd2]) : 32'(e.val));
        rd2++;
      end else check("h2_word_present", 0, 1);
    end
    rd1 = obs1_n;
    rd2 = obs2_n;
  endtask

  vec_t vecs[4];

  initial begin
    int s_wr1, s_wr2, s_d1, s_d2, s_b1, s_b2;
    int lat, c, lows;
    bit ok;

    vecs[0] = '{sel: 2'd0, w: {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[1] = '{sel: 2'd1, w: {16'h0000, 16'h0000, 16'h0000, 16'h0742}};
    vecs[2] = '{sel: 2'd2, w: {16'h0070, 16'h0000, 16'h0000, 16'h0000}};
    vecs[3] = '{sel: 2'd3, w: {16'h0660, 16'h0660, 16'h0660, 16'h0660}};

    reset = 1'b1; load = 1'b0; step_in = 1'b0; pattern_sel = '0;
    repeat (3) cyc();
    check("rst_val", 32'(val), 0);
    check("rst_pos", 32'(pos), 0);
    check("rst_we", 32'(write_enb), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    step_in = 1'b1;
    #1 check("rst_step_pass", 32'(step_out), 1);
    step_in = 1'b0;
    reset = 1'b0;
    repeat (2) cyc();

    // Table-driven loads; sel is changed mid-load and must not matter.
    for (int unsigned v = 0; v < 4; v++) begin
      push_expected(vecs[v].sel, vecs[v].w);
      s_wr1 = obs1_n; s_wr2 = obs2_n; s_d1 = done1_cnt; s_d2 = done2_cnt;
      s_b1 = busy1_cnt; s_b2 = busy2_cnt;
      pattern_sel = vecs[v].sel;
      load = 1'b1;
      lat = 0;
      while (lat < 10 && !write_enb) begin
        cyc();
        lat++;
      end
      check("latency", 32'(lat), 3);
      c = lat;
      cyc(); c++;
      pattern_sel = vecs[v].sel + 2'd2;
      while (c < 10) begin
        cyc();
        c++;
      end
      load = 1'b0;
      c = 0;
      while (c < 40 && !(done1_cnt > s_d1 && done2_cnt > s_d2)) begin
        cyc();
        c++;
      end
      check("done_timeout", 32'(c < 40), 1);
      repeat (2) cyc();
      check("h1_writes", 32'(obs1_n - s_wr1), 4);
      check("h2_writes", 32'(obs2_n - s_wr2), 8);
      check("h1_busy_cycles", 32'(busy1_cnt - s_b1), 5);
      check("h2_busy_cycles", 32'(busy2_cnt - s_b2), 9);
      check("h1_done_pulses", 32'(done1_cnt - s_d1), 1);
      check("h2_done_pulses", 32'(done2_cnt - s_d2), 1);
      drain();
    end

    // Second edge while busy is dropped; held load gives one load; steps gated while busy.
    push_expected(2'd2, vecs[2].w);
    s_wr1 = obs1_n; s_wr2 = obs2_n; s_d1 = done1_cnt; s_d2 = done2_cnt;
    pattern_sel = 2'd2;
    step_in = 1'b1;
    lows = 0;
    load = 1'b1;
    c = 0;
    while (c < 10 && !busy) begin
      cyc();
      c++;
      if (!step_out) lows++;
    end
    check("busy_timeout", 32'(busy), 1);
    cyc(); if (!step_out) lows++;
    load = 1'b0;
    cyc(); if (!step_out) lows++;
    load = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (!step_out) lows++;
    end
    load = 1'b0;
    repeat (5) begin
      cyc();
      if (!step_out) lows++;
    end
    step_in = 1'b0;
    check("step_low_cycles", 32'(lows), 5);
    check("held_h1_writes", 32'(obs1_n - s_wr1), 4);
    check("held_h2_writes", 32'(obs2_n - s_wr2), 8);
    check("held_h1_done", 32'(done1_cnt - s_d1), 1);
    check("held_h2_done", 32'(done2_cnt - s_d2), 1);
    drain();

    // Reset during word 1 aborts at once, with no done pulse afterwards.
    s_d1 = done1_cnt; s_d2 = done2_cnt;
    pattern_sel = 2'd1;
    load = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      if (write_enb && pos == 2'd1) ok = 1'b1;
    end
    check("reach_word1", 32'(ok), 1);
    #1 reset = 1'b1;
    #1;
    check("abort_val", 32'(val), 0);
    check("abort_pos", 32'(pos), 0);
    check("abort_we", 32'(write_enb), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_h2_we", 32'(write_enb2), 0);
    load = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (8) cyc();
    check("abort_no_done_h1", 32'(done1_cnt - s_d1), 0);
    check("abort_no_done_h2", 32'(done2_cnt - s_d2), 0);
    check("abort_idle_busy", 32'(busy), 0);
    rd1 = obs1_n;
    rd2 = obs2_n;

    // Pattern 3 immediately after reset release.
    push_expected(2'd3, vecs[3].w);
    s_wr1 = obs1_n; s_wr2 = obs2_n;
    pattern_sel = 2'd3;
    load = 1'b1;
    repeat (20) cyc();
    load = 1'b0;
    repeat (4) cyc();
    check("post_rst_h1_writes", 32'(obs1_n - s_wr1), 4);
    check("post_rst_h2_writes", 32'(obs2_n - s_wr2), 8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
